// File: rtl/montgomery_pkg.sv
// rtl/montgomery_pkg.sv - shared types for the Montgomery exponentiation controller
package montgomery_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_XT_START,
    ST_XT_WAIT,
    ST_SCAN,
    ST_M1_START,
    ST_M1_WAIT,
    ST_M2_START,
    ST_M2_WAIT,
    ST_NEXT,
    ST_FIN_START,
    ST_FIN_WAIT,
    ST_DONE
  } state_e;

  localparam logic MODE_SQM    = 1'b0;
  localparam logic MODE_LADDER = 1'b1;

  typedef enum logic [2:0] {
    OP_ZERO,
    OP_ONE,
    OP_X,
    OP_R2,
    OP_A0,
    OP_A1
  } op_sel_e;

endpackage

// File: rtl/exp_bit_scanner.sv
// rtl/exp_bit_scanner.sv - latched exponent with MSB-first bit-index down counter
module exp_bit_scanner
  import montgomery_pkg::*;
#(
  parameter int EXP_WIDTH = 512,
  parameter int CNT_W     = $clog2(EXP_WIDTH)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 load_i,
  input  logic                 skip_i,
  input  logic                 dec_i,
  input  logic [EXP_WIDTH-1:0] e_i,
  output logic                 cur_bit_o,
  output logic                 last_bit_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(EXP_WIDTH - 1);

  logic [EXP_WIDTH-1:0] e_q, e_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  assign cur_bit_o  = e_q[cnt_q];
  assign last_bit_o = (cnt_q == '0);

  // Counter never wraps: both skip and explicit decrement stop at bit 0.
  always_comb begin
    e_d   = e_q;
    cnt_d = cnt_q;
    if (load_i) begin
      e_d   = e_i;
      cnt_d = CNT_MAX;
    end else if (!last_bit_o && (dec_i || (skip_i && !cur_bit_o))) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_q   <= '0;
      cnt_q <= CNT_MAX;
    end else begin
      e_q   <= e_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/montgomery_exp_param.sv
// rtl/montgomery_exp_param.sv - x^e mod m controller driving an external Montgomery multiplier
module montgomery_exp_param
  import montgomery_pkg::*;
#(
  parameter int WIDTH     = 512,
  parameter int EXP_WIDTH = 512,
  parameter int CNT_W     = $clog2(EXP_WIDTH)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_r,
  input  logic [WIDTH-1:0]     in_r2,
  output logic                 mm_start,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [WIDTH-1:0]     mm_m,
  input  logic [WIDTH-1:0]     mm_res,
  input  logic                 mm_done,
  output logic [WIDTH-1:0]     res,
  output logic                 busy,
  output logic                 done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, m_q, m_d, r2_q, r2_d;
  logic [WIDTH-1:0] a0_q, a0_d, a1_q, a1_d, res_q, res_d;
  logic             mode_q, mode_d;
  logic             scan_load, scan_skip, scan_dec;
  logic             cur_bit, last_bit, ladder;
  op_sel_e          sel_a, sel_b;

  exp_bit_scanner #(
    .EXP_WIDTH(EXP_WIDTH),
    .CNT_W    (CNT_W)
  ) u_scanner (
    .clk       (clk),
    .resetn    (resetn),
    .load_i    (scan_load),
    .skip_i    (scan_skip),
    .dec_i     (scan_dec),
    .e_i       (in_e),
    .cur_bit_o (cur_bit),
    .last_bit_o(last_bit)
  );

  assign ladder = (mode_q == MODE_LADDER);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    m_d       = m_q;
    r2_d      = r2_q;
    mode_d    = mode_q;
    a0_d      = a0_q;
    a1_d      = a1_q;
    res_d     = res_q;
    scan_load = 1'b0;
    scan_skip = 1'b0;
    scan_dec  = 1'b0;
    sel_a     = OP_ZERO;
    sel_b     = OP_ZERO;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d       = in_x;
          m_d       = in_m;
          r2_d      = in_r2;
          mode_d    = mode;
          a0_d      = in_r;
          scan_load = 1'b1;
          state_d   = ST_XT_START;
        end
      end
      ST_XT_START, ST_XT_WAIT: begin
        sel_a = OP_X;
        sel_b = OP_R2;
        if (state_q == ST_XT_START) begin
          state_d = ST_XT_WAIT;
        end else if (mm_done) begin
          a1_d    = mm_res;
          state_d = ladder ? ST_M1_START : ST_SCAN;
        end
      end
      ST_SCAN: begin
        scan_skip = 1'b1;
        if (cur_bit)       state_d = ST_M1_START;
        else if (last_bit) state_d = ST_FIN_START;
      end
      // Ladder: M1 is always A0*A1; its destination is picked by the bit.
      ST_M1_START, ST_M1_WAIT: begin
        sel_a = OP_A0;
        sel_b = ladder ? OP_A1 : OP_A0;
        if (state_q == ST_M1_START) begin
          state_d = ST_M1_WAIT;
        end else if (mm_done) begin
          if (ladder && !cur_bit) a1_d = mm_res;
          else                    a0_d = mm_res;
          state_d = (ladder || cur_bit) ? ST_M2_START : ST_NEXT;
        end
      end
      ST_M2_START, ST_M2_WAIT: begin
        sel_a = (ladder && cur_bit) ? OP_A1 : OP_A0;
        sel_b = (ladder && !cur_bit) ? OP_A0 : OP_A1;
        if (state_q == ST_M2_START) begin
          state_d = ST_M2_WAIT;
        end else if (mm_done) begin
          if (ladder && cur_bit) a1_d = mm_res;
          else                   a0_d = mm_res;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (last_bit) begin
          state_d = ST_FIN_START;
        end else begin
          scan_dec = 1'b1;
          state_d  = ST_M1_START;
        end
      end
      ST_FIN_START, ST_FIN_WAIT: begin
        sel_a = OP_A0;
        sel_b = OP_ONE;
        if (state_q == ST_FIN_START) begin
          state_d = ST_FIN_WAIT;
        end else if (mm_done) begin
          res_d   = mm_res;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mm_a = '0;
    unique case (sel_a)
      OP_ONE:  mm_a = ONE;
      OP_X:    mm_a = x_q;
      OP_R2:   mm_a = r2_q;
      OP_A0:   mm_a = a0_q;
      OP_A1:   mm_a = a1_q;
      default: mm_a = '0;
    endcase
  end

  always_comb begin
    mm_b = '0;
    unique case (sel_b)
      OP_ONE:  mm_b = ONE;
      OP_X:    mm_b = x_q;
      OP_R2:   mm_b = r2_q;
      OP_A0:   mm_b = a0_q;
      OP_A1:   mm_b = a1_q;
      default: mm_b = '0;
    endcase
  end

  assign mm_start = (state_q == ST_XT_START) || (state_q == ST_M1_START) ||
                    (state_q == ST_M2_START) || (state_q == ST_FIN_START);
  assign mm_m     = m_q;
  assign res      = res_q;
  assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done     = (state_q == ST_DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      m_q     <= '0;
      r2_q    <= '0;
      mode_q  <= MODE_SQM;
      a0_q    <= '0;
      a1_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      m_q     <= m_d;
      r2_q    <= r2_d;
      mode_q  <= mode_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_montgomery_exp_param.sv
// tb/tb_montgomery_exp_param.sv - scoreboard bench with behavioural multiplier and modpow model
module tb_montgomery_exp_param;

  localparam int W   = 16;
  localparam int EW  = 16;
  localparam int LAT = 5;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [W-1:0]  in_x = '0, in_m = '0, in_r = '0, in_r2 = '0;
  logic [EW-1:0] in_e = '0;
  logic          mm_start, mm_done, busy, done;
  logic [W-1:0]  mm_a, mm_b, mm_m, res;
  logic [W-1:0]  mm_res = '0;
  logic          mdl_done = 1'b0, inj_done = 1'b0;

  int           total = 0, bad = 0;
  int           mult_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v, last_exp;

  logic         pend = 1'b0;
  int           lat = 0;
  logic [W-1:0] ca, cb, cm;

  assign mm_done = mdl_done | inj_done;

  montgomery_exp_param #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .mode(mode),
    .in_x(in_x), .in_e(in_e), .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_res(mm_res), .mm_done(mm_done),
    .res(res), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [W-1:0] m);
    logic [63:0] t;
    t = 64'(a) * 64'(b);
    for (int i = 0; i < W; i++) begin
      if (t[0]) t = t + 64'(m);
      t = t >> 1;
    end
    if (t >= 64'(m)) t = t - 64'(m);
    return t[W-1:0];
  endfunction

  function automatic longint modpow(input longint x, input longint e, input longint m);
    longint r, b, k;
    r = 1 % m;
    b = x % m;
    k = e;
    while (k > 0) begin
      if (k % 2 == 1) r = (r * b) % m;
      b = (b * b) % m;
      k = k / 2;
    end
    return r;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend     <= 1'b0;
      mdl_done <= 1'b0;
      lat      <= 0;
      mm_res   <= '0;
    end else begin
      mdl_done <= 1'b0;
      if (pend) begin
        if (lat <= 1) begin
          pend     <= 1'b0;
          mdl_done <= 1'b1;
          mm_res   <= mont(ca, cb, cm);
        end else begin
          lat <= lat - 1;
        end
      end else if (mm_start) begin
        pend     <= 1'b1;
        lat      <= LAT;
        ca       <= mm_a;
        cb       <= mm_b;
        cm       <= mm_m;
        mult_cnt <= mult_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && mm_start) check("mm_start_while_pending", longint'(pend), 0);
  end

  always @(negedge clk) begin
    if (resetn && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_v = exp_q.pop_front();
        check("res", res, exp_v);
        check("busy_low_at_done", busy, 0);
      end
    end
  end

  task automatic drive_start(input logic [W-1:0] x, input logic [EW-1:0] e,
                             input logic [W-1:0] m, input logic md);
    in_x  = x;
    in_e  = e;
    in_m  = m;
    in_r  = W'((64'd1 << W) % 64'(m));
    in_r2 = W'((64'd1 << (2 * W)) % 64'(m));
    mode  = md;
    start = 1'b1;
    last_exp = W'(modpow(longint'(x), longint'(e), longint'(m)));
    exp_q.push_back(last_exp);
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [EW-1:0] e, input logic [W-1:0] m,
                        input logic md, input bit poke, output int cyc, output int nmul);
    int g, m0;
    g = 0;
    @(negedge clk);
    while ((busy || done) && g < 5000) begin
      @(negedge clk);
      g++;
    end
    drive_start(x, e, m, md);
    m0 = mult_cnt;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 20) begin
        in_x  = ~x;
        in_e  = ~e;
        mode  = ~md;
        start = 1'b1;
      end
      if (poke && cyc == 21) start = 1'b0;
    end
    if (!done) check("timeout_waiting_done", 0, 1);
    nmul = mult_cnt - m0;
    if (poke) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_in_done_ignored", busy, 0);
      repeat (3) @(negedge clk);
      check("still_idle_after_done_start", busy, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c5, cf, c1, n, c, g, m0;
    logic [W-1:0] rm, rx;
    logic [EW-1:0] re;
    logic rmd;

    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_res", res, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mm_start", mm_start, 0);
    check("rst_mm_a", mm_a, 0);
    check("rst_mm_b", mm_b, 0);
    check("rst_mm_m", mm_m, 0);
    resetn = 1'b1;

    run_op(16'd3, 16'd5, 16'd13, 1'b0, 1'b0, c, n);
    check("sqm_e5_mults", n, 7);
    @(negedge clk);
    check("busy_low_after", busy, 0);
    check("done_single_pulse", done, 0);

    run_op(16'd3, 16'd5, 16'd13, 1'b1, 1'b0, c5, n);
    check("ladder_mults", n, 2 + 2 * EW);
    run_op(16'd3, 16'hFFFF, 16'd13, 1'b1, 1'b0, cf, n);
    run_op(16'd3, 16'h0001, 16'd13, 1'b1, 1'b0, c1, n);
    check("ladder_cycles_e_ffff", cf, c5);
    check("ladder_cycles_e_0001", c1, c5);

    run_op(16'd7, 16'd0, 16'd11, 1'b0, 1'b0, c, n);
    check("sqm_e0_mults", n, 2);
    run_op(16'd7, 16'd0, 16'd11, 1'b1, 1'b0, c, n);
    run_op(16'd5, 16'd1, 16'd23, 1'b0, 1'b0, c, n);
    run_op(16'd5, 16'd1, 16'd23, 1'b1, 1'b0, c, n);
    run_op(16'd2, 16'hFFFF, 16'hFFF1, 1'b0, 1'b0, c, n);
    run_op(16'd2, 16'hFFFF, 16'hFFF1, 1'b1, 1'b0, c, n);

    run_op(16'd11, 16'h1234, 16'h8001, 1'b0, 1'b1, c, n);

    @(negedge clk);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    check("spurious_done_busy", busy, 0);
    check("spurious_done_mm_start", mm_start, 0);
    check("spurious_done_res", res, last_exp);
    @(negedge clk);
    check("spurious_done_mm_start_later", mm_start, 0);

    drive_start(16'd3, 16'd5, 16'd13, 1'b1);
    m0 = mult_cnt;
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (mult_cnt - m0 < 2 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("reached_m1_wait", mult_cnt - m0, 2);
    @(negedge clk);
    resetn = 1'b0;
    exp_q.delete();
    #1;
    check("abort_res", res, 0);
    check("abort_busy", busy, 0);
    check("abort_mm_start", mm_start, 0);
    check("abort_mm_a", mm_a, 0);
    check("abort_mm_m", mm_m, 0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_done_after", done, 0);
    run_op(16'd3, 16'd5, 16'd13, 1'b1, 1'b0, c, n);

    for (int i = 0; i < 12; i++) begin
      rm  = W'($urandom_range(3, 65535)) | 16'd1;
      rx  = W'($urandom_range(0, int'(rm) - 1));
      re  = EW'($urandom);
      rmd = 1'($urandom);
      run_op(rx, re, rm, rmd, 1'b0, c, n);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/montgomery_exp_param.md
Name: montgomery_exp_param

Overview:
Parametrised modular exponentiation controller computing res = x^e mod m in Montgomery domain. Drives one external Montgomery multiplier over a start/done handshake; R mod M and R^2 mod M arrive precomputed, so no internal mod unit. Supports fast square-and-multiply with leading-zero skip, or constant-time Montgomery ladder, selected per operation. Sits between the RSA top-level register interface and the shared Montgomery multiplier.

Parameters:
WIDTH, 512, operand/modulus width in bits; R = 2^WIDTH.
EXP_WIDTH, 512, exponent width in bits.
CNT_W, $clog2(EXP_WIDTH), bit-index counter width (derived).

Ports:
clk  in  1  clock, all logic on rising edge.
resetn  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request; operands sampled this cycle.
mode  in  1  0 = square-and-multiply, 1 = Montgomery ladder (constant time).
in_x  in  WIDTH  base, must satisfy in_x < in_m.
in_e  in  EXP_WIDTH  exponent.
in_m  in  WIDTH  odd modulus.
in_r  in  WIDTH  R mod M.
in_r2  in  WIDTH  R^2 mod M.
mm_start  out  1  one-cycle pulse to multiplier.
mm_a, mm_b  out  WIDTH  multiplier operands, stable from mm_start until mm_done.
mm_m  out  WIDTH  latched modulus.
mm_res  in  WIDTH  multiplier result, valid when mm_done=1.
mm_done  in  1  one-cycle completion pulse.
res  out  WIDTH  result, held until next accepted start.
busy  out  1  high from cycle after accepted start until done.
done  out  1  one-cycle pulse when res valid.

Behaviour:
- Reset (async, resetn=0): state IDLE; res=0, busy=0, done=0, mm_start=0, mm_a/mm_b/mm_m=0, counter=EXP_WIDTH-1.
- IDLE: start=1 latches x,e,m,r,r2,mode; A0<=r; -> XT_START. start while busy ignored.
- XT_START: mm_start=1, mm_a=x, mm_b=r2 -> XT_WAIT. XT_WAIT: on mm_done, A1<=mm_res (x~); -> SCAN (mode 0) or M1_START (mode 1).
- SCAN (mode 0 only): one bit per cycle; while e[cnt]=0 and cnt>0, cnt--. If e[cnt]=1 -> M1_START. If cnt=0 and e[0]=0 (e==0) -> FIN_START.
- Mode 0 per bit: M1 = A0*A0 -> A0; M2 only if e[cnt]=1: A0*A1 -> A0.
- Mode 1 per bit (all EXP_WIDTH bits, no skip): bit=1: M1 A0*A1 -> A0, M2 A1*A1 -> A1; bit=0: M1 A0*A1 -> A1, M2 A0*A0 -> A0. M2 always issued.
- Each Mx_START: one-cycle mm_start, -> Mx_WAIT; Mx_WAIT holds until mm_done, writes destination same edge.
- NEXT: cnt=0 -> FIN_START; else cnt--, -> M1_START.
- FIN_START/FIN_WAIT: A0*1 (mm_b = 1) -> res; -> DONE.
- DONE: done=1 for exactly one cycle, busy=0 same cycle, -> IDLE. start in DONE ignored; accepted from IDLE next cycle.
- mm_done outside a WAIT state ignored. mm_start never asserted twice without an intervening mm_done.
- Mode 1: total cycles start->done independent of e value (function of EXP_WIDTH and multiplier latency only).
- e==0: result 1 (both modes). e==1: result x.
- Reset mid-operation: immediate abort to reset values; no done pulse; multiplier assumed reset by same resetn.
- All arithmetic in multiplier; controller only muxes WIDTH-bit registers, CNT_W-bit down counter, no wrap (NEXT checks cnt=0 before decrement).

Decomposition:
- Package montgomery_pkg: state enum, MODE_SQM=0 / MODE_LADDER=1 constants, operand-select enum for mm_a/mm_b mux.
- One sub-module: exp_bit_scanner (latched exponent, down counter, leading-zero skip, cur_bit, last_bit flags).

Test Plan:
- WIDTH=16, EXP_WIDTH=16, behavioural multiplier latency 5: x=3, e=5, m=13, mode 0 -> res=9, one done pulse, busy low after.
- Same operands, mode 1 -> res=9; cycle count equals that of e=0xFFFF and e=0x0001 in mode 1.
- x=7, e=0, m=11, both modes -> res=1; mode 0 issues exactly 2 multiplications (x~, final).
- x=5, e=1, m=23 -> res=5; x=2, e=0xFFFF, m=0xFFF1 -> res matches reference model 2^65535 mod 65521.
- start pulsed during busy and in DONE cycle -> ignored, result unchanged; spurious mm_done in IDLE -> no state change.
- resetn low mid M1_WAIT -> res=0, busy=0, done never pulses; new start after release yields correct result.
